dct_block_assembler: RTL and testbench
======================================

DCT_BLOCK_ASSEMBLER -- requirements
Module: dct_block_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of one output matrix element.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, meaning block edge length (block = DATA_DEPTH x DATA_DEPTH).
REQ-003 SHALL have parameter FRAC_BITS, default 8, meaning fractional bits of the signed fixed-point output format.
REQ-004 SHALL have parameter LEVEL_SHIFT, default 1, meaning subtract 128 from each pixel when 1, pass unsigned when 0.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port pix_valid, input, 1, meaning pix_data is valid.
REQ-008 SHALL have port pix_ready, output, 1, meaning the block accepts a pixel this cycle.
REQ-009 SHALL have port pix_data, input, 8, meaning unsigned pixel, row-major raster order within one block.
REQ-010 SHALL have port pix_last, input, 1, meaning the sender marks the final (64th) pixel of a block.
REQ-011 SHALL have port blk_valid, output, 1, meaning blk_data holds a complete block.
REQ-012 SHALL have port blk_ready, input, 1, meaning the downstream DCT stage consumes the block this cycle.
REQ-013 SHALL have port blk_data, output, DATA_WIDTH*DATA_DEPTH*DATA_DEPTH, meaning element (r,c) at bits [(r*DATA_DEPTH+c)*DATA_WIDTH +: DATA_WIDTH], row-major, directly connectable to the 2-D DCT data_in_matrix.
REQ-014 SHALL have port frame_err, output, 1, meaning sticky flag for a pix_last/count mismatch.

Function
REQ-015 SHALL accept a pixel exactly when pix_valid and pix_ready are both 1 in the same cycle.
REQ-016 SHALL hold two storage banks of 64 x 8-bit pixels (ping-pong), a write-bank pointer, a read-bank pointer, one full flag per bank, and a 6-bit write counter.
REQ-017 SHALL drive pix_ready = NOT full[write bank], combinationally from registers.
REQ-018 SHALL store an accepted pixel at index wr_cnt of the write bank and increment wr_cnt.
REQ-019 SHALL, on acceptance with wr_cnt = 63, set full[write bank], toggle the write-bank pointer, and wrap wr_cnt to 0 in that same cycle.
REQ-020 SHALL drive blk_valid = full[read bank]; latency is exactly 1 cycle from the acceptance of pixel 63 to blk_valid high, when that bank is the read bank.
REQ-021 SHALL, on blk_valid and blk_ready both 1, clear full[read bank] and toggle the read-bank pointer.
REQ-022 SHALL hold blk_valid and blk_data stable until that transfer completes.
REQ-023 SHALL honour a pixel write to one bank and a block read of the other bank in the same cycle; sustained throughput is one block per 64 cycles with no bubbles.
REQ-024 SHALL stall (pix_ready = 0) when both banks are full, and release pix_ready in the cycle after a block transfer.
REQ-025 SHALL compute each element as (pixel - 128 when LEVEL_SHIFT = 1, else pixel) as a signed value, shifted left by FRAC_BITS and sign-extended to DATA_WIDTH.
REQ-026 SHALL drive blk_data to all zeros while blk_valid = 0.
REQ-027 SHALL set frame_err when pix_last = 1 on an accepted pixel with wr_cnt != 63, or pix_last = 0 on an accepted pixel with wr_cnt = 63; block completion still follows wr_cnt only.
REQ-028 SHALL keep frame_err set until reset.

Reset
REQ-029 SHALL, in the cycle reset is sampled high, clear both full flags, both bank pointers, wr_cnt, and frame_err.
REQ-030 SHALL therefore present blk_valid = 0, blk_data = 0, pix_ready = 1, and frame_err = 0 in the cycle after reset.
REQ-031 SHALL discard any partial or held block on reset mid-operation; pixel storage itself needs no reset.

Structure
REQ-032 SHALL place in the shared DCT package: the default DATA_WIDTH, DATA_DEPTH, and FRAC_BITS constants, the level-shift constant 128, and the element-index function r*DATA_DEPTH+c.
REQ-033 SHALL be a single module with no sub-modules; the per-element pixel-to-fixed-point conversion is a generate loop.

Verification
REQ-034 Single block: 64 pixels all 200, pix_last on the 64th, blk_ready = 1 -> blk_valid high 1 cycle after pixel 63; every element = 72<<8 = 0x00004800; blk_valid low next cycle.
REQ-035 Ramp block: pixel k = k (0..63), blk_ready = 0 -> element 0 = 0xFFFF8000 (-128<<8), element 63 = 0xFFFFBF00 (-65<<8); the held data stays unchanged for 10 cycles.
REQ-036 Back-pressure: send 3 blocks with blk_ready = 0 -> pix_ready drops after pixel 63 of block 2 (128 accepted); raise blk_ready for 1 cycle -> pix_ready returns next cycle; block 1 is emitted before block 2.
REQ-037 Streaming: continuous pix_valid and blk_ready = 1 for 4 blocks -> pix_ready is never low; blk_valid pulses every 64 cycles; contents match the golden model.
REQ-038 Framing error: pix_last on pixel 10 -> frame_err = 1 from the next cycle, stays 1; the block still completes at pixel 63.
REQ-039 Mid-block reset: reset after 30 pixels -> blk_valid = 0 and pix_ready = 1; the next 64 pixels form a clean first block.

Source files
------------

// File: rtl/dct_block_assembler_pkg.sv
// Shared DCT constants and helpers used by the block assembler
// and the downstream 2-D transform stage.
package dct_block_assembler_pkg;

    localparam int DCT_DATA_WIDTH   = 32;
    localparam int DCT_DATA_DEPTH   = 8;
    localparam int DCT_FRAC_BITS    = 8;
    localparam int DCT_LEVEL_OFFSET = 128;

    function automatic int elem_idx(
        input int r,
        input int c,
        input int depth
    );
        return r * depth + c;
    endfunction

endpackage

// File: rtl/dct_block_assembler.sv
// Collects raster pixels into ping-pong banks and presents each
// finished block as a level-shifted fixed-point matrix.
module dct_block_assembler
    import dct_block_assembler_pkg::*;
#(
    parameter int DATA_WIDTH  = DCT_DATA_WIDTH,
    parameter int DATA_DEPTH  = DCT_DATA_DEPTH,
    parameter int FRAC_BITS   = DCT_FRAC_BITS,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    input  logic       pix_last,
    output logic       blk_valid,
    input  logic       blk_ready,
    output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] blk_data,
    output logic       frame_err
);

    localparam int NPIX  = DATA_DEPTH * DATA_DEPTH;
    localparam int CNT_W = $clog2(NPIX);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

    localparam logic [8:0] OFFSET =
        (LEVEL_SHIFT != 0) ? 9'(DCT_LEVEL_OFFSET) : 9'd0;

    logic [7:0]       bank_mem [2][NPIX];
    logic             wr_bank;
    logic             rd_bank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [CNT_W-1:0] wr_cnt;
    logic             accept;
    logic             take;
    logic             at_last;

    assign pix_ready = ~full[wr_bank];
    assign blk_valid = full[rd_bank];
    assign accept    = pix_valid & pix_ready;
    assign take      = blk_valid & blk_ready;
    assign at_last   = (wr_cnt == LAST_IDX);

    // A write and a read never target the same bank in one cycle,
    // since the write bank is empty and the read bank is full.
    always_comb begin
        full_nxt = full;
        if (take) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (accept && at_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_cnt <= at_last ? '0 : wr_cnt + CNT_W'(1);
                if (at_last) begin
                    wr_bank <= ~wr_bank;
                end
                if (pix_last != at_last) begin
                    frame_err <= 1'b1;
                end
            end
            if (take) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bank_mem[wr_bank][wr_cnt] <= pix_data;
        end
    end

    for (genvar r = 0; r < DATA_DEPTH; r++) begin : g_row
        for (genvar c = 0; c < DATA_DEPTH; c++) begin : g_col
            localparam int IDX = elem_idx(r, c, DATA_DEPTH);

            logic [7:0]            pix;
            logic [8:0]            val;
            logic [DATA_WIDTH-1:0] wide;

            assign pix  = bank_mem[rd_bank][IDX];
            assign val  = {1'b0, pix} - OFFSET;
            assign wide = {{(DATA_WIDTH-9){val[8]}}, val} << FRAC_BITS;

            assign blk_data[IDX*DATA_WIDTH +: DATA_WIDTH] =
                blk_valid ? wide : '0;
        end
    end

endmodule

// File: tb/tb_dct_block_assembler.sv
// Randomized bench for the block assembler against a
// two-block FIFO reference model.
module tb_dct_block_assembler;

    localparam int DW = 32;
    localparam int DD = 8;
    localparam int NP = DD * DD;

    logic           clk = 1'b0;
    logic           reset;
    logic           pix_valid;
    logic           pix_ready;
    logic [7:0]     pix_data;
    logic           pix_last;
    logic           blk_valid;
    logic           blk_ready;
    logic [DW*NP-1:0] blk_data;
    logic           frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pixels of the open block, then finished blocks in order.
    int cur_q[$];
    int done_q[$];
    bit m_ferr;

    always #5 clk = ~clk;

    dct_block_assembler dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .frame_err (frame_err)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_elem(int p);
        return 32'((p - 128) * 256);
    endfunction

    task automatic check_outputs();
        int nblk;
        nblk = done_q.size() / NP;
        check("pix_ready", pix_ready, nblk < 2);
        check("blk_valid", blk_valid, nblk > 0);
        check("frame_err", frame_err, m_ferr);
        for (int i = 0; i < NP; i++) begin
            check("blk_data", blk_data[i*DW +: DW],
                  (nblk > 0) ? ref_elem(done_q[i]) : 32'h0);
        end
    endtask

    task automatic step(bit v, logic [7:0] d, bit last, bit br);
        bit acc;
        bit tk;
        acc = v && (done_q.size() < 2 * NP);
        tk  = br && (done_q.size() >= NP);
        pix_valid = v;
        pix_data  = d;
        pix_last  = last;
        blk_ready = br;
        if (tk) begin
            repeat (NP) void'(done_q.pop_front());
        end
        if (acc) begin
            if (last != (cur_q.size() == NP - 1)) m_ferr = 1'b1;
            cur_q.push_back(int'(d));
            if (cur_q.size() == NP) begin
                done_q = {done_q, cur_q};
                cur_q.delete();
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(logic [7:0] d, bit br);
        step(1'b1, d, cur_q.size() == NP - 1, br);
    endtask

    task automatic idle(bit br);
        step(1'b0, 8'h00, 1'b0, br);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        pix_data  = 8'h00;
        blk_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cur_q.delete();
        done_q.delete();
        m_ferr = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [DW*NP-1:0] held;
        int acc_cnt;
        bit dropped;
        int pulses;
        int last_pos;
        bit v;
        bit br;
        bit last;

        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        pix_data  = 8'h00;
        blk_ready = 1'b0;
        m_ferr    = 1'b0;
        @(negedge clk);

        // single flat block
        do_reset();
        for (int k = 0; k < NP; k++) send(8'd200, 1'b1);
        check("single_valid", blk_valid, 1);
        check("single_e0", blk_data[0 +: DW], 32'h00004800);
        check("single_e63", blk_data[63*DW +: DW], 32'h00004800);
        idle(1'b1);
        check("single_drop", blk_valid, 0);

        // ramp block held under back-pressure
        do_reset();
        for (int k = 0; k < NP; k++) send(8'(k), 1'b0);
        check("ramp_e0", blk_data[0 +: DW], 32'hFFFF8000);
        check("ramp_e63", blk_data[63*DW +: DW], 32'hFFFFBF00);
        held = blk_data;
        repeat (10) idle(1'b0);
        check("ramp_hold", blk_data == held, 1);

        // three blocks against a stalled consumer
        do_reset();
        acc_cnt = 0;
        dropped = 1'b0;
        for (int t = 0; t < 200 && !dropped; t++) begin
            if (!pix_ready) begin
                dropped = 1'b1;
            end else begin
                send(8'($urandom), 1'b0);
                acc_cnt++;
            end
        end
        check("bp_drop", dropped, 1);
        check("bp_count", acc_cnt, 128);
        idle(1'b1);
        check("bp_release", pix_ready, 1);
        for (int k = 0; k < NP; k++) send(8'($urandom), 1'b0);
        repeat (4) idle(1'b1);
        check("bp_empty", blk_valid, 0);

        // streaming with no stalls
        do_reset();
        pulses   = 0;
        last_pos = -1;
        for (int t = 0; t < 4 * NP + 2; t++) begin
            if (t < 4 * NP) send(8'($urandom), 1'b1);
            else idle(1'b1);
            check("stream_ready", pix_ready, 1);
            if (blk_valid) begin
                pulses++;
                if (last_pos >= 0) check("stream_gap", t - last_pos, NP);
                last_pos = t;
            end
        end
        check("stream_pulses", pulses, 4);

        // early pix_last
        do_reset();
        for (int k = 0; k < NP; k++) begin
            step(1'b1, 8'($urandom), (k == 10) || (k == NP - 1), 1'b0);
            if (k == 10) check("ferr_set", frame_err, 1);
        end
        check("ferr_blk", blk_valid, 1);
        idle(1'b1);
        idle(1'b0);
        check("ferr_sticky", frame_err, 1);

        // reset in the middle of a block
        do_reset();
        repeat (30) send(8'($urandom), 1'b0);
        do_reset();
        check("mr_ready", pix_ready, 1);
        check("mr_valid", blk_valid, 0);
        for (int k = 0; k < NP; k++) send(8'($urandom), 1'b0);
        check("mr_blk", blk_valid, 1);
        check("mr_ferr", frame_err, 0);

        // random traffic with occasional framing faults
        do_reset();
        repeat (3000) begin
            v    = ($urandom_range(0, 9) < 7);
            br   = ($urandom_range(0, 9) < 4);
            last = (cur_q.size() == NP - 1);
            if ($urandom_range(0, 199) == 0) last = ~last;
            step(v, 8'($urandom), last, br);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
